// File: rtl/fetch_line_buffer_pkg.sv
// Shared defaults and FSM state encoding for the line-based fetch stage.
package fetch_line_buffer_pkg;

  localparam int unsigned FETCH_ADDR_LEN   = 32;
  localparam int unsigned FETCH_INSN_LEN   = 32;
  localparam int unsigned FETCH_LINE_INSNS = 4;
  localparam int unsigned FETCH_DEQ_W      = 2;
  localparam int unsigned FETCH_IBUF_DEPTH = 8;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_line_buffer_ibuf.sv
// Circular {pc,insn} buffer: up to LINE_INSNS writes and DEQ_W reads per cycle, with flush.
module fetch_ibuf #(
  parameter int unsigned ADDR_LEN   = 32,
  parameter int unsigned INSN_LEN   = 32,
  parameter int unsigned LINE_INSNS = 4,
  parameter int unsigned DEQ_W      = 2,
  parameter int unsigned IBUF_DEPTH = 8,
  localparam int unsigned PTR_W  = $clog2(IBUF_DEPTH),
  localparam int unsigned CNT_W  = $clog2(IBUF_DEPTH + 1),
  localparam int unsigned WCNT_W = $clog2(LINE_INSNS + 1),
  localparam int unsigned RCNT_W = $clog2(DEQ_W + 1),
  localparam int unsigned ENT_W  = ADDR_LEN + INSN_LEN
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic [WCNT_W-1:0]           wr_cnt_i,
  input  logic [LINE_INSNS*ENT_W-1:0] wr_data_i,
  input  logic [RCNT_W-1:0]           rd_cnt_i,
  output logic [CNT_W-1:0]            count_o,
  output logic [DEQ_W*ENT_W-1:0]      rd_data_o
);

  logic [ENT_W-1:0] mem_q [IBUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush drops everything by collapsing head onto tail.
  always_comb begin
    head_d  = head_q + PTR_W'(rd_cnt_i);
    tail_d  = tail_q + PTR_W'(wr_cnt_i);
    count_d = count_q + CNT_W'(wr_cnt_i) - CNT_W'(rd_cnt_i);
    if (flush_i) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned j = 0; j < LINE_INSNS; j++) begin
      if (!flush_i && (j < 32'(wr_cnt_i)))
        mem_q[tail_q + PTR_W'(j)] <= wr_data_i[j*ENT_W +: ENT_W];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEQ_W; k++)
      rd_data_o[k*ENT_W +: ENT_W] = mem_q[head_q + PTR_W'(k)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_line_buffer.sv
// Fetch stage: owns the PC, requests whole lines, buffers the tail of each line, feeds DEQ_W decode slots.
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter int unsigned ADDR_LEN   = FETCH_ADDR_LEN,
  parameter int unsigned INSN_LEN   = FETCH_INSN_LEN,
  parameter int unsigned LINE_INSNS = FETCH_LINE_INSNS,
  parameter int unsigned DEQ_W      = FETCH_DEQ_W,
  parameter int unsigned IBUF_DEPTH = FETCH_IBUF_DEPTH,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           redirect_i,
  input  logic [ADDR_LEN-1:0]            redirect_pc_i,
  output logic                           imem_req_valid_o,
  input  logic                           imem_req_ready_i,
  output logic [ADDR_LEN-1:0]            imem_addr_o,
  input  logic                           imem_resp_valid_i,
  input  logic [LINE_INSNS*INSN_LEN-1:0] imem_resp_data_i,
  output logic [DEQ_W-1:0]               inst_valid_o,
  output logic [DEQ_W*INSN_LEN-1:0]      inst_o,
  output logic [DEQ_W*ADDR_LEN-1:0]      inst_pc_o,
  input  logic                           dec_ready_i
);

  localparam int unsigned OFF_W  = $clog2(LINE_INSNS);
  localparam int unsigned LSB_W  = OFF_W + 2;
  localparam int unsigned WCNT_W = $clog2(LINE_INSNS + 1);
  localparam int unsigned RCNT_W = $clog2(DEQ_W + 1);
  localparam int unsigned CNT_W  = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned ENT_W  = ADDR_LEN + INSN_LEN;

  fetch_state_e                state_q, state_d;
  logic [ADDR_LEN-1:0]         fetch_pc_q, fetch_pc_d;
  logic                        boot_q;
  logic [OFF_W-1:0]            off, src_idx;
  logic [ADDR_LEN-1:0]         line_base;
  logic [WCNT_W-1:0]           n_enq, wr_cnt;
  logic [RCNT_W-1:0]           n_deq;
  logic [CNT_W-1:0]            ibuf_count;
  logic [LINE_INSNS*ENT_W-1:0] wr_data;
  logic [DEQ_W*ENT_W-1:0]      rd_data;
  logic [DEQ_W-1:0]            slot_valid;
  logic                        space_ok, resp_take;

  assign off       = fetch_pc_q[LSB_W-1:2];
  assign line_base = fetch_pc_q & ~ADDR_LEN'((1 << LSB_W) - 1);
  assign n_enq     = WCNT_W'(LINE_INSNS) - WCNT_W'(off);
  assign space_ok  = (32'(ibuf_count) + LINE_INSNS) <= IBUF_DEPTH;

  // boot_q keeps the request side quiet for the first cycle out of reset.
  assign imem_req_valid_o = (state_q == S_REQ) && space_ok && !redirect_i && !reset_i && !boot_q;
  assign imem_addr_o      = line_base;
  assign resp_take        = (state_q == S_WAIT) && imem_resp_valid_i && !redirect_i && !reset_i;
  assign wr_cnt           = resp_take ? n_enq : '0;

  // Realign the line so buffer write slot 0 carries the word at the fetch PC.
  always_comb begin
    src_idx = '0;
    wr_data = '0;
    for (int unsigned j = 0; j < LINE_INSNS; j++) begin
      src_idx = OFF_W'(32'(off) + j);
      wr_data[j*ENT_W +: ENT_W] = {line_base + ADDR_LEN'({src_idx, 2'b00}),
                                   imem_resp_data_i[32'(src_idx)*INSN_LEN +: INSN_LEN]};
    end
  end

  always_comb begin
    n_deq = '0;
    if (dec_ready_i && !redirect_i && !reset_i)
      n_deq = (32'(ibuf_count) < DEQ_W) ? RCNT_W'(ibuf_count) : RCNT_W'(DEQ_W);
  end

  always_comb begin
    slot_valid = '0;
    inst_o     = '0;
    inst_pc_o  = '0;
    for (int unsigned k = 0; k < DEQ_W; k++) begin
      slot_valid[k] = (32'(ibuf_count) > k) && !redirect_i && !reset_i;
      if (slot_valid[k]) begin
        inst_o[k*INSN_LEN +: INSN_LEN]    = rd_data[k*ENT_W +: INSN_LEN];
        inst_pc_o[k*ADDR_LEN +: ADDR_LEN] = rd_data[k*ENT_W + INSN_LEN +: ADDR_LEN];
      end
    end
  end

  assign inst_valid_o = slot_valid;

  // Redirect wins; a request already in flight must have its response swallowed in S_DROP.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~ADDR_LEN'(3);
      if ((state_q inside {S_WAIT, S_DROP}) && !imem_resp_valid_i)
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:  if (imem_req_valid_o && imem_req_ready_i) state_d = S_WAIT;
        S_WAIT: if (imem_resp_valid_i) begin
                  fetch_pc_d = line_base + ADDR_LEN'(LINE_INSNS * 4);
                  state_d    = S_REQ;
                end
        S_DROP: if (imem_resp_valid_i) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      boot_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      boot_q     <= 1'b0;
    end
  end

  fetch_ibuf #(
    .ADDR_LEN  (ADDR_LEN),
    .INSN_LEN  (INSN_LEN),
    .LINE_INSNS(LINE_INSNS),
    .DEQ_W     (DEQ_W),
    .IBUF_DEPTH(IBUF_DEPTH)
  ) u_ibuf (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush_i  (redirect_i),
    .wr_cnt_i (wr_cnt),
    .wr_data_i(wr_data),
    .rd_cnt_i (n_deq),
    .count_o  (ibuf_count),
    .rd_data_o(rd_data)
  );

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Randomized bench for fetch_line_buffer against a PC-queue reference model.
module tb_fetch_line_buffer;

  localparam int AL    = 32;
  localparam int IL    = 32;
  localparam int LI    = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 8;
  localparam logic [AL-1:0] RST_PC = 32'h0;
  localparam logic [AL-1:0] HI_PC  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1, redirect_i = 1'b0, req_ready_i = 1'b0;
  logic          resp_valid_i = 1'b0, dec_ready_i = 1'b0;
  logic [AL-1:0] redirect_pc_i = '0;
  logic [LI*IL-1:0] resp_data_i = '0;
  logic          req_valid_o;
  logic [AL-1:0] addr_o;
  logic [DW-1:0] inst_valid_o;
  logic [DW*IL-1:0] inst_o;
  logic [DW*AL-1:0] inst_pc_o;

  logic          h_reset = 1'b1, h_ready = 1'b0, h_resp_valid = 1'b0, h_dec_ready = 1'b0;
  logic [LI*IL-1:0] h_resp_data = '0;
  logic          h_req_valid;
  logic [AL-1:0] h_addr;
  logic [DW-1:0] h_inst_valid;
  logic [DW*IL-1:0] h_inst;
  logic [DW*AL-1:0] h_inst_pc;

  fetch_line_buffer #(.LINE_INSNS(LI), .DEQ_W(DW), .IBUF_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .reset_i(reset_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(req_valid_o), .imem_req_ready_i(req_ready_i), .imem_addr_o(addr_o),
    .imem_resp_valid_i(resp_valid_i), .imem_resp_data_i(resp_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .dec_ready_i(dec_ready_i));

  fetch_line_buffer #(.LINE_INSNS(LI), .DEQ_W(DW), .IBUF_DEPTH(DEPTH), .RESET_PC(HI_PC)) dut_hi (
    .clk_i(clk), .reset_i(h_reset), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_valid_o(h_req_valid), .imem_req_ready_i(h_ready), .imem_addr_o(h_addr),
    .imem_resp_valid_i(h_resp_valid), .imem_resp_data_i(h_resp_data),
    .inst_valid_o(h_inst_valid), .inst_o(h_inst), .inst_pc_o(h_inst_pc), .dec_ready_i(h_dec_ready));

  int unsigned n_checks = 0, n_fails = 0;

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      if (n_fails <= 40) $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [IL-1:0] insn_of(input logic [AL-1:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: buffered PCs in program order plus the fetch/memory transaction state.
  logic [AL-1:0] q[$];
  logic [AL-1:0] fpc = RST_PC, pend_addr = '0;
  bit  boot = 1'b0, outst = 1'b0, stale = 1'b0, pend_v = 1'b0, just_acc = 1'b0;
  int  pend_n = 0, consumed = 0;

  int  p_rst = 0, p_redir = 0, p_ready = 100, p_dec = 100, lat_min = 1, lat_max = 1, mode = 0;
  bit  force_rst = 1'b0, force_redir = 1'b0;
  logic [AL-1:0] force_pc = '0;

  task automatic one_cycle();
    bit rst, redir, rdy, dr, resp, req_exp, acc;
    logic [AL-1:0] rpc, lbase;
    int nv;
    logic [DW-1:0] vexp;
    @(posedge clk); #1;
    rst  = force_rst || (int'($urandom_range(999, 0)) < p_rst);
    resp = 1'b0;
    if (pend_v && !rst) begin
      pend_n--;
      resp = (pend_n == 0);
    end
    rdy   = int'($urandom_range(99, 0)) < p_ready;
    dr    = int'($urandom_range(99, 0)) < p_dec;
    redir = !rst && (int'($urandom_range(99, 0)) < p_redir);
    rpc   = 32'($urandom_range(511, 0));
    req_exp = !rst && !boot && !outst && (q.size() + LI <= DEPTH);
    if (!rst) begin
      case (mode)
        1: if (just_acc) redir = 1'b1;
        2: if (resp) redir = 1'b1;
        3: if (req_exp && rdy) redir = 1'b1;
        default: ;
      endcase
    end
    if (force_redir) begin
      redir = 1'b1;
      rpc   = force_pc;
    end
    if (redir) req_exp = 1'b0;

    reset_i = rst; redirect_i = redir; redirect_pc_i = rpc;
    req_ready_i = rdy; dec_ready_i = dr; resp_valid_i = resp;
    for (int k = 0; k < LI; k++)
      resp_data_i[k*IL +: IL] = resp ? insn_of(pend_addr + 32'(4*k)) : '0;
    #3;

    nv = redir ? 0 : ((q.size() < DW) ? q.size() : DW);
    if (rst || boot) begin
      expect_eq("quiet_req_valid", 64'(req_valid_o), 0);
      expect_eq("quiet_inst_valid", 64'(inst_valid_o), 0);
      expect_eq("quiet_inst", 64'(inst_o), 0);
      expect_eq("quiet_inst_pc", 64'(inst_pc_o), 0);
    end else begin
      expect_eq("req_valid", 64'(req_valid_o), 64'(req_exp));
      if (req_exp) expect_eq("req_addr", 64'(addr_o), 64'(fpc & ~32'hF));
      vexp = DW'((1 << nv) - 1);
      expect_eq("inst_valid", 64'(inst_valid_o), 64'(vexp));
      for (int k = 0; k < nv; k++) begin
        expect_eq("slot_pc", 64'(inst_pc_o[k*AL +: AL]), 64'(q[k]));
        expect_eq("slot_insn", 64'(inst_o[k*IL +: IL]), 64'(insn_of(q[k])));
      end
      expect_eq("count_bound", 64'(32'(dut.ibuf_count) <= DEPTH), 1);
    end

    if (rst) begin
      q.delete(); fpc = RST_PC; outst = 0; stale = 0; pend_v = 0; boot = 1; just_acc = 0;
    end else begin
      boot = 0;
      acc  = req_exp && rdy;
      if (dr && !redir) begin
        for (int k = 0; k < nv; k++) void'(q.pop_front());
        consumed += nv;
      end
      if (resp) begin
        outst = 0; pend_v = 0;
        if (!stale && !redir) begin
          lbase = fpc & ~32'hF;
          for (int k = int'(fpc[3:2]); k < LI; k++) q.push_back(lbase + 32'(4*k));
          fpc = lbase + 32'h10;
        end
        stale = 0;
      end
      if (redir) begin
        q.delete();
        fpc = rpc & ~32'h3;
        if (outst) stale = 1;
      end
      if (acc) begin
        outst = 1; stale = 0; pend_v = 1;
        pend_n = int'($urandom_range(lat_max, lat_min));
        pend_addr = fpc & ~32'hF;
      end
      just_acc = acc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_cycle();
  endtask

  task automatic h_cyc(input logic rst, input logic rdy, input logic rv);
    @(posedge clk); #1;
    h_reset = rst; h_ready = rdy; h_resp_valid = rv; h_dec_ready = 1'b1;
    for (int k = 0; k < LI; k++) h_resp_data[k*IL +: IL] = insn_of(32'hFFFF_FFF0 + 32'(4*k));
    #3;
  endtask

  initial begin
    force_rst = 1; run(2); force_rst = 0;
    run(12);                                               // 1-cycle memory, decode always ready
    force_redir = 1; force_pc = 32'h2B; run(1); force_redir = 0;
    run(10);
    p_dec = 0; run(20); p_dec = 100; run(10);              // decode stall fills the buffer
    mode = 1; lat_min = 3; lat_max = 3; run(30); mode = 0; run(10);
    lat_min = 1; lat_max = 4; p_ready = 80;
    mode = 2; run(40); mode = 3; run(40); mode = 0; run(10);
    force_redir = 1; force_pc = 32'hFFFF_FFF8; run(1); force_redir = 0;
    p_ready = 0; run(3); p_ready = 100; run(8);            // address wrap at top of memory
    p_redir = 4; p_ready = 70; p_dec = 60; p_rst = 3; run(3000);
    p_rst = 0; p_redir = 0; run(20);
    expect_eq("progress", 64'(consumed > 500), 1);

    // Instance with RESET_PC near the top of the address space.
    h_cyc(1, 0, 0);
    expect_eq("hi_rst_req_valid", 64'(h_req_valid), 0);
    expect_eq("hi_rst_inst_valid", 64'(h_inst_valid), 0);
    h_cyc(0, 0, 0);
    expect_eq("hi_boot_req_valid", 64'(h_req_valid), 0);
    for (int i = 0; i < 3; i++) begin
      h_cyc(0, 0, 0);
      expect_eq("hi_hold_req_valid", 64'(h_req_valid), 1);
      expect_eq("hi_hold_addr", 64'(h_addr), 64'(32'hFFFF_FFF0));
    end
    h_cyc(0, 1, 0);
    expect_eq("hi_acc_addr", 64'(h_addr), 64'(32'hFFFF_FFF0));
    h_cyc(0, 0, 1);
    expect_eq("hi_wait_req_valid", 64'(h_req_valid), 0);
    expect_eq("hi_wait_inst_valid", 64'(h_inst_valid), 0);
    h_cyc(0, 0, 0);
    expect_eq("hi_inst_valid", 64'(h_inst_valid), 64'(2'b11));
    expect_eq("hi_pc0", 64'(h_inst_pc[0 +: AL]), 64'(32'hFFFF_FFF8));
    expect_eq("hi_pc1", 64'(h_inst_pc[AL +: AL]), 64'(32'hFFFF_FFFC));
    expect_eq("hi_insn0", 64'(h_inst[0 +: IL]), 64'(insn_of(32'hFFFF_FFF8)));
    expect_eq("hi_insn1", 64'(h_inst[IL +: IL]), 64'(insn_of(32'hFFFF_FFFC)));
    expect_eq("hi_next_req_valid", 64'(h_req_valid), 1);
    expect_eq("hi_next_addr", 64'(h_addr), 0);
    h_cyc(0, 0, 0);
    expect_eq("hi_drained", 64'(h_inst_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
